dataless_rr_arbiter: RTL and testbench

DATALESS_RR_ARBITER -- requirements
Module: dataless_rr_arbiter

---
 rtl/dataless_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_dataless_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dataless_rr_arbiter.sv
// Dataless N:1 arbiter feeding one registered output slot (EMPTY/FULL), one token per cycle.
// Define DATALESS_ARB_ROUND_ROBIN_EN for round-robin selection; the default build is fixed priority.
module dataless_rr_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    output logic [INDEX_WIDTH-1:0] index
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    slot_state_e            state_q;
    slot_state_e            state_d;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] index_d;

    logic                   slot_open_s;
    logic                   grant_valid_s;
    logic [INDEX_WIDTH-1:0] grant_s;
    logic                   in_hs_s;
    logic [NUM_INPUTS-1:0]  ins_ready_s;

`ifdef DATALESS_ARB_ROUND_ROBIN_EN
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic [INDEX_WIDTH-1:0] ptr_d;
    logic [INDEX_WIDTH:0]   cand_sum_s;
    logic [INDEX_WIDTH-1:0] cand_s;
    logic [INDEX_WIDTH:0]   ptr_next_sum_s;

    // Round-robin selection: first asserted requester at or above the pointer, wrapping to 0.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = {INDEX_WIDTH{1'b0}};
        cand_sum_s    = {(INDEX_WIDTH+1){1'b0}};
        cand_s        = {INDEX_WIDTH{1'b0}};
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand_sum_s = {1'b0, ptr_q} + (INDEX_WIDTH+1)'(k);
            if (cand_sum_s >= (INDEX_WIDTH+1)'(NUM_INPUTS)) begin
                cand_s = INDEX_WIDTH'(cand_sum_s - (INDEX_WIDTH+1)'(NUM_INPUTS));
            end else begin
                cand_s = cand_sum_s[INDEX_WIDTH-1:0];
            end
            if (ins_valid[cand_s] && !grant_valid_s) begin
                grant_valid_s = 1'b1;
                grant_s       = cand_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Pointer moves just past the winner, only when a token is actually accepted.
    always_comb begin
        ptr_d          = ptr_q;
        ptr_next_sum_s = {1'b0, grant_s} + {{INDEX_WIDTH{1'b0}}, 1'b1};
        if (in_hs_s) begin
            if (ptr_next_sum_s >= (INDEX_WIDTH+1)'(NUM_INPUTS)) begin
                ptr_d = {INDEX_WIDTH{1'b0}};
            end else begin
                ptr_d = ptr_next_sum_s[INDEX_WIDTH-1:0];
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= {INDEX_WIDTH{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority selection: lowest-numbered asserted requester wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = {INDEX_WIDTH{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (ins_valid[i] && !grant_valid_s) begin
                grant_valid_s = 1'b1;
                grant_s       = INDEX_WIDTH'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end
`endif

    assign slot_open_s = (state_q == SLOT_EMPTY) || outs_ready;
    assign in_hs_s     = rst && slot_open_s && grant_valid_s;

    // One-hot ready to the selected requester; gated by reset so nothing is accepted while held.
    always_comb begin
        ins_ready_s = {NUM_INPUTS{1'b0}};
        if (in_hs_s) begin
            ins_ready_s[grant_s] = 1'b1;
        end else begin
            ins_ready_s = {NUM_INPUTS{1'b0}};
        end
    end

    // Slot next state: load on accept, drain on output-only handshake, otherwise hold.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (in_hs_s) begin
            state_d = SLOT_FULL;
            index_d = grant_s;
        end else if ((state_q == SLOT_FULL) && outs_ready) begin
            state_d = SLOT_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            index_q <= {INDEX_WIDTH{1'b0}};
        end else begin
            case (state_q)
                SLOT_EMPTY: state_q <= state_d;
                SLOT_FULL:  state_q <= state_d;
                default:    state_q <= SLOT_EMPTY;
            endcase
            index_q <= index_d;
        end
    end

    assign ins_ready  = ins_ready_s;
    assign outs_valid = (state_q == SLOT_FULL);
    assign index      = index_q;

endmodule

// File: tb/tb_dataless_rr_arbiter.sv
// Directed bench for dataless_rr_arbiter: reset, arbitration order, backpressure, in/out overlap.
module tb_dataless_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ins_valid = 4'b0000;
    logic       outs_ready = 1'b0;
    logic [3:0] ins_ready;
    logic       outs_valid;
    logic [1:0] index;

    int n_assert = 0;
    int n_fail   = 0;

    dataless_rr_arbiter #(
        .NUM_INPUTS (4),
        .INDEX_WIDTH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready),
        .index     (index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held from time zero with every requester asserted.
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(outs_valid), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_ready", 32'(ins_ready), 32'd0);
        cyc();
        chk("rst_valid_edge", 32'(outs_valid), 32'd0);
        chk("rst_ready_edge", 32'(ins_ready), 32'd0);

`ifdef DATALESS_ARB_ROUND_ROBIN_EN
        @(negedge clk);
        rst       = 1'b1;
        ins_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", 32'(ins_ready), 32'(4'b0001 << (k % 4)));
            cyc();
            chk("rr_valid", 32'(outs_valid), 32'd1);
            chk("rr_index", 32'(index), 32'(k % 4));
        end
`else
        @(negedge clk);
        rst       = 1'b1;
        ins_valid = 4'b1010;
        #1;
        chk("fp_first_ready", 32'(ins_ready), 32'(4'b0010));
        cyc();
        chk("fp_first_valid", 32'(outs_valid), 32'd1);
        chk("fp_first_index", 32'(index), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("fp_hold_ready", 32'(ins_ready), 32'(4'b0010));
            cyc();
            chk("fp_hold_index", 32'(index), 32'd1);
        end
        ins_valid = 4'b1000;
        #1;
        chk("fp_drop_ready", 32'(ins_ready), 32'(4'b1000));
        cyc();
        chk("fp_drop_index", 32'(index), 32'd3);
`endif

        // Load index 1, then backpressure for 5 cycles.
        ins_valid  = 4'b0010;
        outs_ready = 1'b1;
        cyc();
        chk("bp_load_index", 32'(index), 32'd1);
        outs_ready = 1'b0;
        ins_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 32'(ins_ready), 32'd0);
            cyc();
            chk("bp_valid", 32'(outs_valid), 32'd1);
            chk("bp_index", 32'(index), 32'd1);
        end

        // Drain with nothing requesting; index holds while EMPTY.
        outs_ready = 1'b1;
        ins_valid  = 4'b0000;
        #1;
        chk("drain_ready", 32'(ins_ready), 32'd0);
        cyc();
        chk("drain_valid", 32'(outs_valid), 32'd0);
        chk("drain_index", 32'(index), 32'd1);
        cyc();
        chk("idle_valid", 32'(outs_valid), 32'd0);
        chk("idle_index", 32'(index), 32'd1);

        // Simultaneous input and output handshake.
        ins_valid = 4'b0001;
        cyc();
        chk("sim_load_valid", 32'(outs_valid), 32'd1);
        chk("sim_load_index", 32'(index), 32'd0);
        ins_valid = 4'b0100;
        #1;
        chk("sim_ready", 32'(ins_ready), 32'(4'b0100));
        cyc();
        chk("sim_valid", 32'(outs_valid), 32'd1);
        chk("sim_index", 32'(index), 32'd2);

        // Two requesters 0 and 2: pointer sits at 3 in round-robin mode, so 0 then 2 either way.
        ins_valid = 4'b0101;
        #1;
        chk("wrap_ready0", 32'(ins_ready), 32'(4'b0001));
        cyc();
        chk("wrap_index0", 32'(index), 32'd0);
`ifndef DATALESS_ARB_ROUND_ROBIN_EN
        ins_valid = 4'b0100;
`endif
        #1;
        chk("wrap_ready2", 32'(ins_ready), 32'(4'b0100));
        cyc();
        chk("wrap_index2", 32'(index), 32'd2);
        chk("wrap_valid2", 32'(outs_valid), 32'd1);

        // Asynchronous reset while FULL with index 2.
        outs_ready = 1'b0;
        ins_valid  = 4'b1111;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(outs_valid), 32'd0);
        chk("arst_index", 32'(index), 32'd0);
        chk("arst_ready", 32'(ins_ready), 32'd0);
        @(negedge clk);
        rst        = 1'b1;
        outs_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ins_ready), 32'(4'b0001));
        cyc();
        chk("post_rst_index", 32'(index), 32'd0);
        chk("post_rst_valid", 32'(outs_valid), 32'd1);
        ins_valid = 4'b0100;
        #1;
        chk("post_rst_ready2", 32'(ins_ready), 32'(4'b0100));
        cyc();
        chk("post_rst_index2", 32'(index), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
